// File: rtl/udpip_tx_framer_if.sv
// rtl/udpip_tx_framer_if.sv - byte-stream handshake bundle between a packet source, the UDP/IPv4 framer and the frame sink
interface udpip_tx_framer_if;
  logic [7:0] tx_in;
  logic       tx_in_valid;
  logic       tx_in_first;
  logic       tx_in_last;
  logic       tx_in_ready;
  logic [7:0] wrdata;
  logic       wr_valid;
  logic       wr_first;
  logic       wr_last;
  logic       wr_ready;

  modport master (
    output tx_in, tx_in_valid, tx_in_first, tx_in_last, wr_ready,
    input  tx_in_ready, wrdata, wr_valid, wr_first, wr_last
  );

  modport slave (
    input  tx_in, tx_in_valid, tx_in_first, tx_in_last, wr_ready,
    output tx_in_ready, wrdata, wr_valid, wr_first, wr_last
  );
endinterface

// File: rtl/udpip_tx_framer.sv
// rtl/udpip_tx_framer.sv - store-and-forward UDP/IPv4 transmit framer; UDP_CHECKSUM_EN enables the UDP checksum
module udpip_tx_framer #(
  parameter int         MAX_PAYLOAD = 1472,
  parameter logic [7:0] TTL         = 8'd64,
  parameter logic [7:0] TOS         = 8'd0,
  parameter bit         DF          = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  udpip_tx_framer_if.slave bus,
  output logic             err_drop,
  output logic             busy
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);
  // Fixed IP header words: version/IHL+TOS, flags/fragment, TTL+protocol.
  localparam logic [31:0] IP_CONST = 32'({8'h45, TOS}) + 32'({1'b0, DF, 14'h0}) + 32'({TTL, 8'h11});

  typedef enum logic [3:0] {
    S_IDLE, S_DESC, S_PAYLOAD, S_DROP, S_LEN, S_FOLD, S_CPL, S_HDR, S_PAY
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      desc [0:13];
  logic [3:0]      desc_idx;
  logic [CW-1:0]   pay_cnt;
  logic [AW-1:0]   rd_addr;
  logic [4:0]      hdr_idx;
  logic [31:0]     ip_acc;
  logic [15:0]     udp_csum;
  logic [7:0]      mem [0:MAX_PAYLOAD-1];

  logic            xfer_in, xfer_out, drop_pulse, load_desc;
  logic            pay_full, pay_last, byte_even;
  logic [31:0]     byte_word;
  logic [15:0]     tot_len, udp_len;
  logic [4:0]      desc_sel;
  logic [7:0]      hdr_byte;

  // Two end-around-carry folds bring any 32-bit sum down to 16 bits.
  function automatic logic [31:0] fold2(input logic [31:0] s);
    logic [31:0] t;
    t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return {16'h0, t[15:0]} + {16'h0, t[31:16]};
  endfunction

  assign xfer_in   = bus.tx_in_valid && bus.tx_in_ready;
  assign xfer_out  = bus.wr_valid && bus.wr_ready;
  assign pay_full  = (pay_cnt == MAX_CNT);
  assign pay_last  = ((CW'(rd_addr) + CW'(1)) == pay_cnt);
  assign tot_len   = 16'(pay_cnt) + 16'd28;
  assign udp_len   = 16'(pay_cnt) + 16'd8;
  // Even byte positions are the high half of a 16-bit word, so each byte is added pre-shifted.
  assign byte_even = (state == S_PAYLOAD) ? ~pay_cnt[0] : ~desc_idx[0];
  assign byte_word = byte_even ? {16'h0, bus.tx_in, 8'h00} : {24'h0, bus.tx_in};
  assign desc_sel  = hdr_idx - 5'd12;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, including drop decisions and descriptor restarts.
  always_comb begin
    state_nxt  = state;
    drop_pulse = 1'b0;
    load_desc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (xfer_in && bus.tx_in_first) begin
          load_desc = 1'b1;
          if (bus.tx_in_last) drop_pulse = 1'b1;
          else                state_nxt  = S_DESC;
        end
      end
      S_DESC, S_PAYLOAD, S_DROP: begin
        if (xfer_in) begin
          if (bus.tx_in_first) begin
            drop_pulse = 1'b1;
            load_desc  = 1'b1;
            state_nxt  = bus.tx_in_last ? S_IDLE : S_DESC;
          end else if (state == S_DESC) begin
            if (desc_idx == 4'd13) begin
              state_nxt = bus.tx_in_last ? S_LEN : S_PAYLOAD;
            end else if (bus.tx_in_last) begin
              drop_pulse = 1'b1;
              state_nxt  = S_IDLE;
            end
          end else if (state == S_PAYLOAD) begin
            if (pay_full) begin
              drop_pulse = 1'b1;
              state_nxt  = bus.tx_in_last ? S_IDLE : S_DROP;
            end else if (bus.tx_in_last) begin
              state_nxt = S_LEN;
            end
          end else if (bus.tx_in_last) begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_LEN:  state_nxt = S_FOLD;
      S_FOLD: state_nxt = S_CPL;
      S_CPL:  state_nxt = S_HDR;
      S_HDR: begin
        if (xfer_out && hdr_idx == 5'd27) state_nxt = (pay_cnt == '0) ? S_IDLE : S_PAY;
      end
      S_PAY: begin
        if (xfer_out && pay_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Header byte selection by position within the 28-byte IPv4+UDP header.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      5'd0:  hdr_byte = 8'h45;
      5'd1:  hdr_byte = TOS;
      5'd2:  hdr_byte = tot_len[15:8];
      5'd3:  hdr_byte = tot_len[7:0];
      5'd4:  hdr_byte = desc[12];
      5'd5:  hdr_byte = desc[13];
      5'd6:  hdr_byte = {1'b0, DF, 6'b0};
      5'd7:  hdr_byte = 8'h00;
      5'd8:  hdr_byte = TTL;
      5'd9:  hdr_byte = 8'h11;
      5'd10: hdr_byte = ip_acc[15:8];
      5'd11: hdr_byte = ip_acc[7:0];
      5'd24: hdr_byte = udp_len[15:8];
      5'd25: hdr_byte = udp_len[7:0];
      5'd26: hdr_byte = udp_csum[15:8];
      5'd27: hdr_byte = udp_csum[7:0];
      default: hdr_byte = (hdr_idx >= 5'd12 && hdr_idx <= 5'd23) ? desc[desc_sel[3:0]] : 8'h00;
    endcase
  end

  // Outputs decoded from state; wrdata/first/last depend only on held counters, so they stay put during stalls.
  always_comb begin
    bus.tx_in_ready = (state == S_IDLE) || (state == S_DESC) || (state == S_PAYLOAD) || (state == S_DROP);
    bus.wr_valid    = (state == S_HDR) || (state == S_PAY);
    bus.wr_first    = (state == S_HDR) && (hdr_idx == 5'd0);
    bus.wr_last     = ((state == S_HDR) && (hdr_idx == 5'd27) && (pay_cnt == '0)) ||
                      ((state == S_PAY) && pay_last);
    bus.wrdata      = 8'h00;
    if (state == S_HDR)      bus.wrdata = hdr_byte;
    else if (state == S_PAY) bus.wrdata = mem[rd_addr];
    err_drop        = drop_pulse;
    busy            = (state != S_IDLE);
  end

  // Descriptor capture, payload count, IP checksum accumulation and output indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 14; i++) desc[i] <= 8'h00;
      desc_idx <= 4'd0;
      pay_cnt  <= '0;
      rd_addr  <= '0;
      hdr_idx  <= 5'd0;
      ip_acc   <= 32'h0;
    end else if (load_desc) begin
      desc[0]  <= bus.tx_in;
      desc_idx <= 4'd1;
      pay_cnt  <= '0;
      ip_acc   <= {16'h0, bus.tx_in, 8'h00};
    end else begin
      case (state)
        S_DESC: begin
          if (xfer_in) begin
            desc[desc_idx] <= bus.tx_in;
            desc_idx       <= desc_idx + 4'd1;
            if (desc_idx < 4'd8 || desc_idx >= 4'd12) ip_acc <= ip_acc + byte_word;
          end
        end
        S_PAYLOAD: if (xfer_in && !pay_full) pay_cnt <= pay_cnt + CW'(1);
        S_LEN: begin
          ip_acc  <= ip_acc + IP_CONST + {16'h0, tot_len};
          rd_addr <= '0;
          hdr_idx <= 5'd0;
        end
        S_FOLD: ip_acc <= fold2(ip_acc);
        S_CPL:  ip_acc <= {16'h0, ~ip_acc[15:0]};
        S_HDR:  if (xfer_out) hdr_idx <= hdr_idx + 5'd1;
        S_PAY:  if (xfer_out) rd_addr <= rd_addr + AW'(1);
        default: ;
      endcase
    end
  end

  // Payload buffer write; contents persist across packets.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && xfer_in && !bus.tx_in_first && !pay_full)
      mem[pay_cnt[AW-1:0]] <= bus.tx_in;
  end

`ifdef UDP_CHECKSUM_EN
  logic [31:0] udp_acc;

  // UDP checksum over pseudo-header, ports, length and payload; a zero result goes out as all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      udp_acc <= 32'h0;
    end else if (load_desc) begin
      udp_acc <= {16'h0, bus.tx_in, 8'h00};
    end else begin
      case (state)
        S_DESC:    if (xfer_in && desc_idx < 4'd12) udp_acc <= udp_acc + byte_word;
        S_PAYLOAD: if (xfer_in && !pay_full) udp_acc <= udp_acc + byte_word;
        S_LEN:     udp_acc <= udp_acc + 32'h0000_0011 + {15'h0, udp_len, 1'b0};
        S_FOLD:    udp_acc <= fold2(udp_acc);
        S_CPL:     udp_acc <= {16'h0, (udp_acc[15:0] == 16'hFFFF) ? 16'hFFFF : ~udp_acc[15:0]};
        default: ;
      endcase
    end
  end

  assign udp_csum = udp_acc[15:0];
`else
  assign udp_csum = 16'h0000;
`endif

endmodule

// File: tb/tb_udpip_tx_framer.sv
// tb/tb_udpip_tx_framer.sv - directed self-checking bench for udpip_tx_framer
`timescale 1ns/1ps
module tb_udpip_tx_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_drop, busy;

  udpip_tx_framer_if bus();

  udpip_tx_framer #(.MAX_PAYLOAD(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_drop(err_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  bit         got_first[$];
  bit         got_lastf[$];
  bit         got_last;
  int         first_cyc, last_in_cyc;
  int         stall_err, ready_err, drop_cnt;
  bit         stalled;
  logic [7:0] sd;
  logic       sf, sl;

`ifdef UDP_CHECKSUM_EN
  logic [15:0] ucs_even = 16'hD75D;
  logic [15:0] ucs_odd  = 16'hD82C;
`else
  logic [15:0] ucs_even = 16'h0000;
  logic [15:0] ucs_odd  = 16'h0000;
`endif

  logic [7:0] desc_b[$] = {8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
                           8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output/err monitor sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (stalled && (!bus.wr_valid || bus.wrdata !== sd || bus.wr_first !== sf || bus.wr_last !== sl))
      stall_err++;
    stalled = bus.wr_valid && !bus.wr_ready;
    sd = bus.wrdata; sf = bus.wr_first; sl = bus.wr_last;
    if (bus.wr_valid && bus.wr_ready) begin
      got.push_back(bus.wrdata);
      got_first.push_back(bus.wr_first);
      got_lastf.push_back(bus.wr_last);
      if (bus.wr_first && first_cyc < 0) first_cyc = cyc;
      if (bus.wr_last) got_last = 1'b1;
    end
    if (err_drop) drop_cnt++;
  end

  task automatic clear_mon();
    got.delete(); got_first.delete(); got_lastf.delete();
    got_last = 1'b0; first_cyc = -1; stall_err = 0; ready_err = 0; stalled = 1'b0;
  endtask

  task automatic send_q(input bit with_last);
    @(posedge clk); #1;
    for (int i = 0; i < tx_q.size(); i++) begin
      bus.tx_in       = tx_q[i];
      bus.tx_in_valid = 1'b1;
      bus.tx_in_first = (i == 0);
      bus.tx_in_last  = with_last && (i == tx_q.size() - 1);
      for (int w = 0; w < 50 && !bus.tx_in_ready; w++) begin
        @(posedge clk); #1;
      end
      check_eq($sformatf("in_ready_b%0d", i), {31'h0, bus.tx_in_ready}, 32'd1);
      @(posedge clk); #1;
      if (i == tx_q.size() - 1) last_in_cyc = cyc;
    end
    bus.tx_in_valid = 1'b0;
    bus.tx_in_first = 1'b0;
    bus.tx_in_last  = 1'b0;
  endtask

  task automatic wait_frame(input bit bp);
    int t = 0;
    while (!got_last && t < 400) begin
      @(posedge clk); #1;
      bus.wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!got_last && bus.tx_in_ready) ready_err++;
      t++;
    end
    bus.wr_ready = 1'b1;
    check_eq("frame_done", {31'h0, got_last}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    int nf = 0, nl = 0;
    check_eq({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'h100, {24'h0, exp_q[i]});
    foreach (got_first[i]) nf += int'(got_first[i]);
    foreach (got_lastf[i]) nl += int'(got_lastf[i]);
    check_eq({tag, "_first_pos"}, (got.size() > 0) ? {31'h0, got_first[0]} : 32'h0, 32'd1);
    check_eq({tag, "_first_cnt"}, nf, 32'd1);
    check_eq({tag, "_last_pos"}, (got.size() == exp_q.size()) ? {31'h0, got_lastf[exp_q.size()-1]} : 32'h0, 32'd1);
    check_eq({tag, "_last_cnt"}, nl, 32'd1);
  endtask

  task automatic load_basic();
    tx_q  = {desc_b, 8'hAB, 8'hCD};
    exp_q = {8'h45, 8'h00, 8'h00, 8'h1E, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h11, 8'h26, 8'hCC,
             8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
             8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0A, ucs_even[15:8], ucs_even[7:0], 8'hAB, 8'hCD};
  endtask

  task automatic basic_frame(input string tag, input bit bp);
    clear_mon();
    load_basic();
    send_q(1'b1);
    wait_frame(bp);
    check_frame(tag);
    if (!bp) check_eq({tag, "_latency"}, first_cyc - last_in_cyc, 32'd3);
    check_eq({tag, "_in_ready_held"}, ready_err, 32'd0);
  endtask

  initial begin
    bus.tx_in = 8'h00; bus.tx_in_valid = 1'b0; bus.tx_in_first = 1'b0; bus.tx_in_last = 1'b0;
    bus.wr_ready = 1'b1;
    drop_cnt = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'h0, bus.tx_in_ready}, 32'd1);
    check_eq("rst_wr_valid", {31'h0, bus.wr_valid}, 32'd0);
    check_eq("rst_wr_first", {31'h0, bus.wr_first}, 32'd0);
    check_eq("rst_wr_last", {31'h0, bus.wr_last}, 32'd0);
    check_eq("rst_wrdata", {24'h0, bus.wrdata}, 32'd0);
    check_eq("rst_err_drop", {31'h0, err_drop}, 32'd0);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    basic_frame("basic", 1'b0);

    clear_mon();
    tx_q  = {desc_b, 8'hAB};
    exp_q = {8'h45, 8'h00, 8'h00, 8'h1D, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h11, 8'h26, 8'hCD,
             8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
             8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h09, ucs_odd[15:8], ucs_odd[7:0], 8'hAB};
    send_q(1'b1);
    wait_frame(1'b0);
    check_frame("odd");
    check_eq("odd_latency", first_cyc - last_in_cyc, 32'd3);

    basic_frame("bp", 1'b1);
    check_eq("bp_stall_stable", stall_err, 32'd0);

    drop_cnt = 0;
    clear_mon();
    tx_q = {desc_b, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_q(1'b1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("oversize_drop", drop_cnt, 32'd1);
    check_eq("oversize_no_out", got.size(), 32'd0);

    tx_q = {8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00};
    send_q(1'b1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("runt_drop", drop_cnt, 32'd2);
    check_eq("runt_no_out", got.size(), 32'd0);

    tx_q = {desc_b, 8'h11, 8'h22};
    send_q(1'b0);
    basic_frame("restart", 1'b0);
    check_eq("restart_drop", drop_cnt, 32'd3);

    clear_mon();
    load_basic();
    send_q(1'b1);
    for (int t = 0; t < 200 && got.size() < 10; t++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_at_b10", got.size(), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_wr_valid", {31'h0, bus.wr_valid}, 32'd0);
    check_eq("midrst_in_ready", {31'h0, bus.tx_in_ready}, 32'd1);
    check_eq("midrst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    basic_frame("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
